// File: rtl/imem_stream_loader.sv
// Byte-stream program loader: assembles a length-prefixed little-endian image into
// 32-bit words, writes them to instruction memory, and holds the core in reset until done.
module imem_stream_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StWrite,
        StDone,
        StError
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [31:0]         word_q, word_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH:0] wl_q, wl_d;
    logic [15:0]         len_full;
    logic                xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            len_q      <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
            wl_q       <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            wl_q       <= wl_d;
        end
    end

    // Outputs decode from state/registers only, so in_ready never depends on in_valid.
    always_comb begin
        in_ready     = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
        imem_we      = (state_q == StWrite);
        busy         = in_ready || imem_we;
        done         = (state_q == StDone);
        core_rst_n   = (state_q == StDone);
        error        = (state_q == StError);
        imem_addr    = wl_q[ADDR_WIDTH-1:0];
        imem_wdata   = word_q;
        words_loaded = wl_q;
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        wl_d       = wl_q;
        xfer       = in_valid && in_ready;
        len_full   = {in_data, len_q[7:0]};

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d    = StLenLo;
                    wl_d       = '0;
                    byte_cnt_d = '0;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    len_d[7:0] = in_data;
                    state_d    = StLenHi;
                end
            end
            StLenHi: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    if (len_full == 16'd0) begin
                        state_d = StDone;
                    end else if (32'(len_full) > DEPTH) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    // First byte ends up in [7:0] after four shifts.
                    word_d     = {in_data, word_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                wl_d = wl_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                if (32'(wl_d) == 32'(len_q)) begin
                    state_d = StDone;
                end else begin
                    state_d = StData;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Byte-stream program loader: the writer side of the core's instruction-fetch path.
- Receives a length-prefixed program over a valid/ready byte interface and assembles little-endian 32-bit words.
- Writes each word into the instruction memory write port.
- Holds the pipeline core in reset until the whole image is written, then releases it.

Parameters:
- ADDR_WIDTH, 8: instruction memory word-address width.
- DEPTH, 256: instruction memory depth in words. Must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a load. Sampled only in IDLE, DONE, ERROR.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- imem_addr  output  ADDR_WIDTH  word address of the current write.
- imem_wdata  output  32  assembled instruction word.
- core_rst_n  output  1  active-low reset to the pipeline core.
- busy  output  1  load in progress.
- done  output  1  image fully written; core running.
- error  output  1  length header exceeded DEPTH.
- words_loaded  output  ADDR_WIDTH+1  count of words written in the current load.

Behaviour:
- Reset: clk and rst_n form one clock domain; reset is asynchronous and active-low.
  - rst_n low forces state IDLE immediately.
  - All outputs go to 0: in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, busy, done, error, words_loaded.
  - Any partial word is discarded and no write is issued.
- Byte transfer occurs on a rising edge with in_valid && in_ready.
  - in_ready is a function of state only, never of in_valid.
- Stream format:
  - Two header bytes give word count N, low byte first (16-bit).
  - Then 4*N data bytes. Byte k of a word lands in bits [8k+7:8k], first byte in [7:0].
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR.
  - IDLE: in_ready=0, core_rst_n=0. start → LEN_LO; clears words_loaded and the byte counter.
  - LEN_LO: in_ready=1. On transfer, latch N[7:0] → LEN_HI.
  - LEN_HI: in_ready=1. On transfer, latch N[15:8].
    - If N==0 → DONE.
    - If N>DEPTH → ERROR.
    - Else → DATA.
  - DATA: in_ready=1. Shift each accepted byte into the word register; 2-bit byte counter. After the 4th byte → WRITE.
  - WRITE: in_ready=0. imem_we=1 for exactly one cycle, with imem_addr=words_loaded[ADDR_WIDTH-1:0] and imem_wdata=assembled word. On the next edge words_loaded increments.
    - If the new words_loaded==N → DONE.
    - Else → DATA.
  - DONE: core_rst_n=1, done=1, in_ready=0. start → LEN_LO; core_rst_n drops to 0 on that same edge.
  - ERROR: error=1, core_rst_n=0, in_ready=0. No writes. start → LEN_LO and clears error.
- busy=1 in LEN_LO, LEN_HI, DATA, WRITE.
- start in any busy state is ignored.
- Throughput: one word per 5 cycles minimum (4 accept cycles + 1 write cycle).
- in_valid stalls may occur at any byte; state and partial word are held.
- All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.
- A load with N==DEPTH writes addresses 0..DEPTH-1 and goes to DONE. words_loaded reaches DEPTH, hence the extra bit.
- Bytes offered in IDLE, WRITE, DONE, ERROR are not accepted (in_ready=0).

Test Plan:
- Reset, start, stream 02 00 13 05 40 06 93 05 40 01 with in_valid held high.
  - Two writes: addr0=0x06400513, addr1=0x01400593.
  - done=1 and core_rst_n=1 exactly one cycle after the second imem_we.
  - words_loaded=2. Total cycles from first header byte to done = 2+5+5.
- Same image with in_valid deasserted for 3 cycles between every byte.
  - Identical writes and data. imem_we never asserted while a word is partial.
- Header 00 00 → DONE two cycles after start. No imem_we. core_rst_n=1.
- Header 01 01 (N=257, DEPTH=256) → error=1, core_rst_n=0, in_ready=0, no writes.
  - A subsequent start plus a valid 1-word image clears error and loads addr0.
- rst_n pulsed low after the 2nd data byte of word 1.
  - All outputs 0 immediately. No write to addr1.
  - A fresh start plus a full image loads correctly from addr0.
- After DONE, start pulse with a 1-word image 01 00 EF BE AD DE.
  - core_rst_n drops on the start edge. busy=1 during the load.
  - addr0=0xDEADBEEF written. done reasserts. start pulses during busy have no effect.
